convert_from_10: RTL and testbench
==================================

Name: convert_from_10

Overview:
- Decimal-to-binary converter; the inverse of convert_to_10.
- Accepts a serial stream of BCD digits, MSB digit first, with a valid/ready handshake.
- Accumulates the digits into a WIDTH-bit unsigned binary value: acc = acc*10 + digit.
- The multiply is done chunk-serially, CHUNK bits per cycle, so a 400-bit accumulator stays small in logic.
- Used to load decimal constants/keypad input into e_calc-width datapaths and to loop-back-check convert_to_10 output.

Parameters:
- WIDTH, 400: accumulator/result width in bits; must be a multiple of CHUNK.
- CHUNK, 16: bits processed per MAC cycle; NCHUNK = WIDTH/CHUNK (default 25).
- MAX_DIGITS, 150: maximum digits accepted per conversion.
- CW, 8: width of digit_count; must hold MAX_DIGITS.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  clears accumulator and begins a conversion; honoured only in IDLE or DONE.
- digit  in  4  BCD digit.
- digit_valid  in  1  digit is presented.
- digit_last  in  1  qualifies digit as the final digit of the number.
- ready  out  1  high only in WAIT_DIGIT; a digit is accepted on a cycle with digit_valid & ready.
- binary  out  WIDTH  accumulator; final only while done=1.
- digit_count  out  CW  number of digits accumulated.
- done  out  1  level; high while in DONE.
- overflow  out  1  sticky; value exceeded 2^WIDTH-1 or more than MAX_DIGITS digits offered.
- error  out  1  sticky; a non-BCD digit (>9) was offered.

Behaviour:
- Reset (asynchronous): state=IDLE; ready=0; binary=0; digit_count=0; done=0; overflow=0; error=0; chunk index=0; carry=0.

State machine:
- IDLE:
  - start → clear binary, digit_count, overflow, error; go to WAIT_DIGIT.
  - Otherwise hold.
- WAIT_DIGIT (ready=1). When digit_valid=1:
  - digit>9: set error; do not accumulate or count. If digit_last, go to DONE; else stay.
  - digit_count==MAX_DIGITS: set overflow; discard the digit. If digit_last, go to DONE; else stay.
  - Otherwise: latch carry=digit, latch last_flag=digit_last, chunk index=0, go to MAC.
  - start is ignored in this state.
- MAC (ready=0), one chunk per cycle, LSB chunk first:
  - p = binary[i*CHUNK +: CHUNK]*10 + carry, computed at CHUNK+4 bits.
  - Chunk i ← p[CHUNK-1:0]; carry ← p>>CHUNK. Carry never exceeds 9, so 4 bits suffice.
  - After chunk NCHUNK-1:
    - If the final carry≠0, set overflow; the value wraps modulo 2^WIDTH.
    - digit_count += 1.
    - Next state is DONE if last_flag, else WAIT_DIGIT.
  - start and digit_valid are ignored in MAC.
- DONE (done=1): binary, digit_count and flags are held. start → clear as in IDLE, go to WAIT_DIGIT, done falls next cycle.

Timing:
- Accept edge T: ready is low on cycles T+1 … T+NCHUNK.
- ready is high again at T+NCHUNK+1, or done is high then if the digit was last.
- Throughput: one digit per NCHUNK+1 cycles.
- binary is updated chunk-by-chunk during MAC; the consumer may sample it only when ready or done.

Boundary conditions:
- Zero-digit stream is impossible; digit_last is only meaningful with digit_valid.
- Leading zeros are legal and counted.
- Reset mid-MAC aborts immediately; all outputs return to reset values.
- start held high across DONE→WAIT_DIGIT does not re-clear after the first digit, because start is ignored in WAIT_DIGIT.

Test Plan:
- start; digits 1, 2, 3 (last on the 3), each presented as soon as ready → binary=123, digit_count=3, done=1, overflow=0, error=0; ready low exactly 25 cycles after each accept.
- WIDTH=16, CHUNK=8; digits 6,5,5,3,5 (last) → binary=65535, overflow=0. Repeat with 6,5,5,3,6 → binary=0, overflow=1, done=1.
- Digits 4, 0xC, 2 (last) → error=1, binary=42, digit_count=2.
- 150 digits '9', then one more digit with last → overflow=1 (count saturation), digit_count=150, done=1. Also cross-check binary equals 10^150-1 truncated mod 2^400: carry-overflow also set, since 10^150 > 2^400.
- Assert rst on the 10th MAC cycle of the second digit → all outputs 0, state IDLE. A new start with digits 7 (last) → binary=7.
- Loop-back: feed e_calc ans into convert_to_10, pipe decimal/valid into this block (last on conv_done) → binary equals the original ans bit-for-bit.

Source files
------------

// File: rtl/convert_from_10.sv
// rtl/convert_from_10.sv - serial BCD digit stream to WIDTH-bit binary, chunk-serial multiply-by-ten
module convert_from_10 #(
  parameter int WIDTH      = 400,
  parameter int CHUNK      = 16,
  parameter int MAX_DIGITS = 150,
  parameter int CW         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       digit,
  input  logic             digit_valid,
  input  logic             digit_last,
  output logic             ready,
  output logic [WIDTH-1:0] binary,
  output logic [CW-1:0]    digit_count,
  output logic             done,
  output logic             overflow,
  output logic             error
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int PW     = CHUNK + 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_DIGIT,
    S_MAC,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [IW-1:0]    chunk_idx;
  logic [3:0]       carry;
  logic             last_flag;
  logic [CHUNK-1:0] cur_chunk;
  logic [PW-1:0]    prod;
  logic [3:0]       prod_carry;
  logic             last_chunk;
  logic             digit_bad;
  logic             count_full;

  // One CHUNK-wide slice times ten plus the incoming carry; the carry out never exceeds 9.
  assign cur_chunk  = binary[chunk_idx*CHUNK +: CHUNK];
  assign prod       = PW'(cur_chunk) * PW'(10) + PW'(carry);
  assign prod_carry = prod[PW-1:CHUNK];
  assign last_chunk = (chunk_idx == IW'(NCHUNK - 1));
  assign digit_bad  = (digit > 4'd9);
  assign count_full = (digit_count == CW'(MAX_DIGITS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_WAIT_DIGIT;
      end
      S_WAIT_DIGIT: begin
        ready = 1'b1;
        if (digit_valid) begin
          if (digit_bad || count_full) begin
            if (digit_last) state_next = S_DONE;
          end else begin
            state_next = S_MAC;
          end
        end
      end
      S_MAC: begin
        if (last_chunk) state_next = last_flag ? S_DONE : S_WAIT_DIGIT;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_next = S_WAIT_DIGIT;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      binary      <= '0;
      digit_count <= '0;
      overflow    <= 1'b0;
      error       <= 1'b0;
      chunk_idx   <= '0;
      carry       <= '0;
      last_flag   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            binary      <= '0;
            digit_count <= '0;
            overflow    <= 1'b0;
            error       <= 1'b0;
          end
        end
        S_WAIT_DIGIT: begin
          if (digit_valid) begin
            if (digit_bad) begin
              error <= 1'b1;
            end else if (count_full) begin
              overflow <= 1'b1;
            end else begin
              carry     <= digit;
              last_flag <= digit_last;
              chunk_idx <= '0;
            end
          end
        end
        S_MAC: begin
          binary[chunk_idx*CHUNK +: CHUNK] <= prod[CHUNK-1:0];
          carry                            <= prod_carry;
          if (last_chunk) begin
            // A carry out of the top chunk means the value wrapped modulo 2^WIDTH.
            if (prod_carry != 4'd0) overflow <= 1'b1;
            digit_count <= digit_count + CW'(1);
            chunk_idx   <= '0;
          end else begin
            chunk_idx <= chunk_idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_convert_from_10.sv
// tb/tb_convert_from_10.sv - randomized self-checking bench for convert_from_10 against an arithmetic model
module tb_convert_from_10;

  localparam int WB = 400;
  localparam int CB = 16;
  localparam int MB = 150;
  localparam int WS = 16;
  localparam int CS = 8;
  localparam int MS = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       sel;
  logic       start, digit_valid, digit_last;
  logic [3:0] digit;

  logic          start_b, valid_b, ready_b, done_b, ov_b, err_b;
  logic [WB-1:0] bin_b;
  logic [7:0]    cnt_b;
  logic          start_s, valid_s, ready_s, done_s, ov_s, err_s;
  logic [WS-1:0] bin_s;
  logic [7:0]    cnt_s;

  assign start_b = start & ~sel;
  assign valid_b = digit_valid & ~sel;
  assign start_s = start & sel;
  assign valid_s = digit_valid & sel;

  convert_from_10 #(.WIDTH(WB), .CHUNK(CB), .MAX_DIGITS(MB), .CW(8)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .digit(digit), .digit_valid(valid_b),
    .digit_last(digit_last), .ready(ready_b), .binary(bin_b), .digit_count(cnt_b),
    .done(done_b), .overflow(ov_b), .error(err_b)
  );

  convert_from_10 #(.WIDTH(WS), .CHUNK(CS), .MAX_DIGITS(MS), .CW(8)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .digit(digit), .digit_valid(valid_s),
    .digit_last(digit_last), .ready(ready_s), .binary(bin_s), .digit_count(cnt_s),
    .done(done_s), .overflow(ov_s), .error(err_s)
  );

  logic rdy, dn;
  assign rdy = sel ? ready_s : ready_b;
  assign dn  = sel ? done_s : done_b;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [511:0] m_val;
  int           m_cnt;
  logic         m_ov, m_err;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int cur_w();
    return sel ? WS : WB;
  endfunction

  function automatic int cur_nchunk();
    return sel ? WS / CS : WB / CB;
  endfunction

  task automatic model_reset();
    m_val = '0;
    m_cnt = 0;
    m_ov  = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic model_digit(input int d, output bit acc);
    logic [511:0] wide;
    logic [511:0] mask;
    int maxd;
    maxd = sel ? MS : MB;
    mask = (512'(1) << cur_w()) - 512'(1);
    acc  = 1'b0;
    if (d > 9) begin
      m_err = 1'b1;
    end else if (m_cnt == maxd) begin
      m_ov = 1'b1;
    end else begin
      wide = m_val * 512'(10) + 512'(d);
      if ((wide & ~mask) != '0) m_ov = 1'b1;
      m_val = wide & mask;
      m_cnt++;
      acc = 1'b1;
    end
  endtask

  task automatic wait_free(output int cyc);
    cyc = 0;
    while (!rdy && !dn && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 200) check("wait_bound", 512'(1), 512'(0));
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input int d, input bit last, output int cyc);
    int n;
    n = 0;
    while (!rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rdy) begin
      check("send_ready", 512'(0), 512'(1));
      cyc = 0;
      return;
    end
    digit       = 4'(d);
    digit_valid = 1'b1;
    digit_last  = last;
    @(negedge clk);
    digit_valid = 1'b0;
    digit_last  = 1'b0;
    wait_free(cyc);
  endtask

  task automatic send_model(input int d, input bit last, input string tag);
    int cyc;
    bit acc;
    send(d, last, cyc);
    model_digit(d, acc);
    check({tag, "_lat"}, 512'(cyc), acc ? 512'(cur_nchunk()) : 512'(0));
  endtask

  task automatic check_result(input string tag);
    check({tag, "_bin"}, sel ? 512'(bin_s) : 512'(bin_b), m_val);
    check({tag, "_cnt"}, sel ? 512'(cnt_s) : 512'(cnt_b), 512'(m_cnt));
    check({tag, "_done"}, 512'(dn), 512'(1));
    check({tag, "_ov"}, sel ? 512'(ov_s) : 512'(ov_b), 512'(m_ov));
    check({tag, "_err"}, sel ? 512'(err_s) : 512'(err_b), 512'(m_err));
  endtask

  initial begin
    int len, d;
    int d123[3]  = '{1, 2, 3};
    int dmax[5]  = '{6, 5, 5, 3, 5};
    int dwrap[5] = '{6, 5, 5, 3, 6};
    int derr[3]  = '{4, 12, 2};

    sel = 1'b0; start = 1'b0; digit = '0; digit_valid = 1'b0; digit_last = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", 512'(ready_b), 512'(0));
    check("rst_bin", 512'(bin_b), 512'(0));
    check("rst_cnt", 512'(cnt_b), 512'(0));
    check("rst_done", 512'(done_b), 512'(0));
    check("rst_ov", 512'(ov_b), 512'(0));
    check("rst_err", 512'(err_b), 512'(0));
    rst = 1'b0;

    do_start();
    model_reset();
    for (int i = 0; i < 3; i++) send_model(d123[i], i == 2, "t123");
    check_result("t123");
    check("t123_const", 512'(bin_b), 512'(123));

    sel = 1'b1;
    do_start();
    model_reset();
    for (int i = 0; i < 5; i++) send_model(dmax[i], i == 4, "s_max");
    check_result("s_max");
    check("s_max_const", 512'(bin_s), 512'(65535));
    do_start();
    model_reset();
    for (int i = 0; i < 5; i++) send_model(dwrap[i], i == 4, "s_wrap");
    check_result("s_wrap");
    check("s_wrap_const", 512'(bin_s), 512'(0));
    check("s_wrap_ovc", 512'(ov_s), 512'(1));

    sel = 1'b0;
    do_start();
    model_reset();
    for (int i = 0; i < 3; i++) send_model(derr[i], i == 2, "t_err");
    check_result("t_err");
    check("t_err_const", 512'(bin_b), 512'(42));

    do_start();
    model_reset();
    for (int i = 0; i < MB; i++) send_model(9, 1'b0, "t_nines");
    send_model(9, 1'b1, "t_nines_x");
    check_result("t_nines");
    check("t_nines_cnt150", 512'(cnt_b), 512'(150));
    check("t_nines_ovc", 512'(ov_b), 512'(1));

    do_start();
    begin
      int cyc;
      send(1, 1'b0, cyc);
    end
    digit = 4'd2; digit_valid = 1'b1; digit_last = 1'b0;
    @(negedge clk);
    digit_valid = 1'b0;
    repeat (9) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_ready", 512'(ready_b), 512'(0));
    check("mid_rst_bin", 512'(bin_b), 512'(0));
    check("mid_rst_cnt", 512'(cnt_b), 512'(0));
    check("mid_rst_done", 512'(done_b), 512'(0));
    check("mid_rst_ov", 512'(ov_b), 512'(0));
    check("mid_rst_err", 512'(err_b), 512'(0));
    @(negedge clk);
    check("mid_rst_idle", 512'(ready_b), 512'(0));
    rst = 1'b0;
    do_start();
    model_reset();
    send_model(7, 1'b1, "t7");
    check_result("t7");
    check("t7_const", 512'(bin_b), 512'(7));

    for (int t = 0; t < 20; t++) begin
      do_start();
      model_reset();
      len = $urandom_range(1, 60);
      for (int i = 0; i < len; i++) begin
        d = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
        send_model(d, i == len - 1, "rnd_b");
      end
      check_result("rnd_b");
    end

    sel = 1'b1;
    for (int t = 0; t < 12; t++) begin
      do_start();
      model_reset();
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        d = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
        send_model(d, i == len - 1, "rnd_s");
      end
      check_result("rnd_s");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
